// File: rtl/mem_stage_mmio_pkg.sv
// Shared encodings and store-lane helpers for the MIPS memory stage.
package mem_stage_mmio_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [31:0] BUS_ERR_DATA = 32'h0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } stateT;

  function automatic logic [3:0] storeBe(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: storeBe = 4'b0001 << lo;
      SZ_HALF: storeBe = lo[1] ? 4'b1100 : 4'b0011;
      default: storeBe = 4'b1111;
    endcase
  endfunction

  // Replicate the sub-word so every enabled lane already carries the right bytes.
  function automatic logic [31:0] storeLanes(input logic [1:0] sz, input logic [31:0] rt);
    case (sz)
      SZ_BYTE: storeLanes = {4{rt[7:0]}};
      SZ_HALF: storeLanes = {2{rt[15:0]}};
      default: storeLanes = rt;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_mmio_load_align.sv
// Little-endian load extraction: shift by byte offset, then zero/sign fill.
module mem_stage_mmio_load_align
  import mem_stage_mmio_pkg::*;
(
  input  logic [31:0] rdWord,
  input  logic [1:0]  addrLo,
  input  logic [1:0]  size,
  input  logic        signExt,
  output logic [31:0] data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdWord >> {addrLo, 3'b000};
    case (size)
      SZ_BYTE: data = {{24{signExt & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data = {{16{signExt & shifted[15]}}, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_mmio.sv
// MIPS memory stage: handshaked data memory plus word-aligned MMIO channels
// decoded in the top of the low-byte address space.
module mem_stage_mmio
  import mem_stage_mmio_pkg::*;
#(
  parameter int         NUM_IO   = 2,
  parameter logic [7:0] IO_BASE  = 8'hF0,
  parameter int         MAX_WAIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic                   mem_to_reg,
  input  logic [1:0]             size,
  input  logic                   sign_ext,
  input  logic [31:0]            alu_result,
  input  logic [31:0]            rt_data,
  input  logic [32*NUM_IO-1:0]   io_rdata,
  output logic [NUM_IO-1:0]      io_we,
  output logic [31:0]            io_wdata,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [31:0]            dmem_addr,
  output logic [31:0]            dmem_wdata,
  output logic [3:0]             dmem_be,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_ack,
  output logic                   stall,
  output logic [31:0]            reg_write_data,
  output logic                   wb_valid,
  output logic                   misaligned,
  output logic                   bus_err
);

  stateT             state;
  logic [7:0]        waitCnt;
  logic [31:0]       pendAlu;
  logic [1:0]        pendSize;
  logic              pendSign, pendLoad;
  logic [NUM_IO-1:0] ioHit;
  logic [31:0]       ioWord, alignIn, alignOut;
  logic [1:0]        alignLo, alignSize;
  logic              alignSign;
  logic              isMem, isMis, isIo, isDm, waitLast;

  always_comb begin
    ioHit  = '0;
    ioWord = '0;
    for (int k = 0; k < NUM_IO; k++)
      if (alu_result[7:0] == IO_BASE + 8'(4 * k)) begin
        ioHit[k] = 1'b1;
        ioWord   = io_rdata[32*k +: 32];
      end
  end

  assign isMem    = valid_in & (mem_read | mem_write);
  assign isMis    = isMem & (((size == SZ_HALF) & alu_result[0]) |
                             ((size >= SZ_WORD) & (alu_result[1:0] != 2'b00)));
  assign isIo     = isMem & ~isMis & (|ioHit);
  assign isDm     = isMem & ~isMis & ~(|ioHit);
  assign waitLast = (waitCnt == 8'(MAX_WAIT - 1));
  assign stall    = (state == ST_IDLE) ? isDm : ~(dmem_ack | waitLast);

  // One aligner serves both paths: live I/O word in IDLE, pending dmem load in WAIT.
  assign alignIn   = (state == ST_WAIT) ? dmem_rdata   : ioWord;
  assign alignLo   = (state == ST_WAIT) ? pendAlu[1:0] : alu_result[1:0];
  assign alignSize = (state == ST_WAIT) ? pendSize     : size;
  assign alignSign = (state == ST_WAIT) ? pendSign     : sign_ext;

  mem_stage_mmio_load_align uAlign (
    .rdWord (alignIn),
    .addrLo (alignLo),
    .size   (alignSize),
    .signExt(alignSign),
    .data   (alignOut)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      waitCnt        <= '0;
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= '0;
      dmem_wdata     <= '0;
      dmem_be        <= '0;
      io_we          <= '0;
      io_wdata       <= '0;
      wb_valid       <= 1'b0;
      misaligned     <= 1'b0;
      bus_err        <= 1'b0;
      reg_write_data <= '0;
      pendAlu        <= '0;
      pendSize       <= SZ_BYTE;
      pendSign       <= 1'b0;
      pendLoad       <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      io_we      <= '0;
      case (state)
        ST_IDLE: if (valid_in) begin
          if (isDm) begin
            state      <= ST_WAIT;
            waitCnt    <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_result[31:2], 2'b00};
            dmem_be    <= storeBe(size, alu_result[1:0]);
            dmem_wdata <= storeLanes(size, rt_data);
            pendAlu    <= alu_result;
            pendSize   <= size;
            pendSign   <= sign_ext;
            pendLoad   <= mem_read & ~mem_write & mem_to_reg;
          end else begin
            wb_valid <= 1'b1;
            if (isMis) begin
              misaligned     <= 1'b1;
              reg_write_data <= '0;
            end else if (isIo & mem_write) begin
              io_we          <= ioHit;
              io_wdata       <= rt_data;
              reg_write_data <= alu_result;
            end else if (isIo & mem_to_reg) begin
              reg_write_data <= alignOut;
            end else begin
              reg_write_data <= alu_result;
            end
          end
        end
        ST_WAIT: begin
          waitCnt <= waitCnt + 8'd1;
          if (dmem_ack | waitLast) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wb_valid <= 1'b1;
            // A late ack on the final wait cycle still counts as a completion.
            if (dmem_ack)
              reg_write_data <= pendLoad ? alignOut : pendAlu;
            else begin
              bus_err        <= 1'b1;
              reg_write_data <= BUS_ERR_DATA;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_stage_mmio.md
Name: mem_stage_mmio

Overview:
Parametrised next-generation MIPS memory stage: performs load/store to a handshaked data memory, with byte/halfword/word sizes and sign/zero extension. Decodes NUM_IO word-aligned memory-mapped I/O channels (VGA, gamepad, ...) in the top of the low-byte address space. Produces registered writeback data and a stall to hold the pipeline while data memory is outstanding. Sits between the execute stage and the register-file writeback.

Parameters:
NUM_IO, 2, number of memory-mapped I/O channels (1..4)
IO_BASE, 8'hF0, low-byte address of I/O channel 0; channel k at IO_BASE+4k
MAX_WAIT, 16, cycles in WAIT without dmem_ack before bus-error abort (2..255)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; one clock; synchronous, active-high
valid_in  in  1  instruction present; inputs held stable while stall=1
mem_read  in  1  load operation
mem_write  in  1  store operation
mem_to_reg  in  1  1: writeback load data, 0: writeback alu_result
size  in  2  0 byte, 1 half, 2 word (3 treated as word)
sign_ext  in  1  sign-extend sub-word loads
alu_result  in  32  address or ALU result
rt_data  in  32  store data
io_rdata  in  32*NUM_IO  read data, channel k at bits [32k+31:32k]
io_we  out  NUM_IO  registered one-cycle write strobe per channel
io_wdata  out  32  registered store data to I/O
dmem_req  out  1  registered request, held until ack or abort
dmem_we  out  1  write request
dmem_addr  out  32  word address (alu_result with [1:0] cleared)
dmem_wdata  out  32  lane-replicated store data
dmem_be  out  4  byte enables
dmem_rdata  in  32  read data, valid with dmem_ack
dmem_ack  in  1  completion, single-cycle pulse
stall  out  1  combinational hold request to upstream
reg_write_data  out  32  registered writeback data
wb_valid  out  1  registered one-cycle retire pulse
misaligned  out  1  registered one-cycle alignment fault pulse
bus_err  out  1  registered one-cycle timeout pulse

Behaviour:
- Reset: state IDLE; dmem_req, dmem_we, io_we, wb_valid, misaligned, bus_err = 0; reg_write_data, dmem_addr, dmem_wdata, io_wdata = 0; dmem_be = 0; wait counter 0.
- Classification in IDLE with valid_in: mem = mem_read|mem_write; mis = mem & ((size==1 & addr[0]) | (size>=2 & addr[1:0]!=0)); io = mem & addr[7:0] in {IO_BASE+4k, k<NUM_IO}; dm = mem & ~mis & ~io.
- Non-memory op: next cycle wb_valid=1, reg_write_data=alu_result. Latency 1, no stall.
- mis: no memory or I/O access; next cycle wb_valid=1, misaligned=1, reg_write_data=0.
- io write: next cycle io_we[k]=1, io_wdata=rt_data, wb_valid=1. io read: io_rdata[k] sampled this cycle, formatted per size/sign_ext, reg_write_data next cycle. Undecoded channel numbers never strobe.
- dm: stall=1 combinationally; next cycle state WAIT, dmem_req=1, dmem_we=mem_write, addr/be/wdata registered.
- Store lanes (little-endian): byte: wdata={4{rt[7:0]}}, be=1<<addr[1:0]; half: wdata={2{rt[15:0]}}, be=addr[1]?1100:0011; word: be=1111.
- Load extraction: shift dmem_rdata right by 8*addr[1:0], take 8/16/32 bits, sign_ext selects sign vs zero fill. mem_to_reg=0 on a load writes alu_result instead.
- WAIT: stall=1 except in the ack cycle. On dmem_ack: dmem_req=0 next cycle, wb_valid=1, reg_write_data=formatted load (stores: alu_result), state IDLE; stall=0 in ack cycle so upstream advances.
- Counter increments every WAIT cycle; if it reaches MAX_WAIT with no ack: stall=0 that cycle, next cycle dmem_req=0, bus_err=1, wb_valid=1, reg_write_data=0, IDLE. Ack on the same cycle as timeout wins (normal completion).
- dmem_ack while IDLE is ignored. rst during WAIT: abort, no wb_valid, dmem_req=0 next cycle.
- Back-to-back dm ops: minimum one IDLE cycle between requests.

Decomposition:
- Shared package: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state encoding (ST_IDLE/ST_WAIT), bus-error data constant 32'h0.
- One sub-module natural: mem_load_align (combinational shift/extend of 32-bit word by addr[1:0], size, sign_ext), used for both dmem and I/O read paths.

Test Plan:
- ALU op alu_result=32'h1234 -> next cycle wb_valid=1, reg_write_data=32'h1234, stall never high.
- lb sign_ext=1 addr=0x103, ack after 3 cycles with rdata=32'h80FF_FF00 -> stall 3 cycles, reg_write_data=32'hFFFF_FF80; lbu -> 32'h0000_0080.
- sh addr=0x102 rt=32'hAAAA_BEEF -> dmem_be=1100, dmem_wdata=32'hBEEF_BEEF, dmem_addr=0x100, dmem_we=1.
- sw addr=0xF4, NUM_IO=2 -> io_we=2'b10, io_wdata=rt for one cycle, dmem_req stays 0; lw addr=0xF0 with io_rdata[31:0]=32'h5 -> reg_write_data=5.
- lw addr=0x102 -> misaligned=1, wb_valid=1, reg_write_data=0, no dmem_req.
- lw with no ack, MAX_WAIT=16 -> bus_err pulse after 16 WAIT cycles, reg_write_data=0; repeat with rst asserted in WAIT cycle 2 -> dmem_req low next cycle, no wb_valid.
